i2c_text_register_bank: RTL and testbench
=========================================

Name: i2c_text_register_bank

Overview:
- Parametrised successor of the I2C-slave text register interface. Sits between the I2C slave byte engine (addr/dataIn/writeEn/dataOut) and the text-memory writer of the VGA character generator.
- Holds cursor and attribute registers, and supports a configurable attribute-byte count.
- Adds configurable cursor auto-advance, a screen-fill command, a FIFO-buffered valid/ready output towards text memory, and readable status with a sticky overflow flag.

Parameters:
- COLS, 80, text columns; x wraps at COLS-1.
- ROWS, 25, text rows; y wraps at ROWS-1.
- ATTR_BYTES, 2, attribute bytes per cell (1..4).
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  8  register address from the I2C slave.
- dataIn  in  8  write data.
- writeEn  in  1  one-cycle write strobe.
- dataOut  out  8  read data, registered.
- char_valid  out  1  FIFO head valid.
- char_ready  in  1  text-memory writer accepts the head.
- xtext  out  8  head column.
- ytext  out  8  head row.
- charattr  out  8*(ATTR_BYTES+1)  head cell {attr[ATTR_BYTES-1..0], char}.

Behaviour:
- Reset (async assert, sync-safe release):
  - x, y, all attrs, FIFO pointers/count, overflow = 0.
  - MODE = 0x01 (auto-advance on, row-major).
  - FSM = IDLE.
  - dataOut = 0, char_valid = 0.
- Register map (write via writeEn; reads registered, 1-cycle latency, addr sampled every cycle):
  - 0x00 CHAR (R/W): stores the char. If the push is accepted, enqueues {attrs, char} at the current (x,y), then advances the cursor if MODE[0]=1.
  - 0x01 X, 0x02 Y (R/W): written values ≥ COLS/ROWS are clamped to COLS-1/ROWS-1.
  - 0x03 .. 0x03+ATTR_BYTES-1: attribute bytes (R/W).
  - 0x08 MODE (R/W): bit0 = auto-advance; bit1 = column-major (advance y first); other bits read 0.
  - 0x09 FILL (W): starts the fill with the written char; reads 0.
  - 0x0A STATUS (R): bit0 = FIFO full, bit1 = fill busy, bit2 = overflow. Writing any value clears overflow.
  - Any other address reads 0x00; writes to it are ignored.
- Cursor advance:
  - Row-major: x+1; at x=COLS-1, x=0 and y+1; at y=ROWS-1, y=0.
  - Column-major: the same with x and y swapped.
  - If a write to X/Y occurs in the same cycle as an advance, the explicit write wins (CHAR and X/Y are different addresses, so they cannot coincide within one write).
- FIFO:
  - Push is accepted only when registered count < FIFO_DEPTH. A pop in the same cycle does not free a slot for that cycle's push.
  - Pop occurs on char_valid && char_ready. char_valid = (count != 0).
  - xtext, ytext and charattr always show the head entry and stay stable while char_valid && !char_ready.
  - A rejected CHAR push sets overflow and does not advance the cursor.
- FSM IDLE/FILL:
  - IDLE→FILL on a write to 0x09. On entry, snapshots the fill char and attrs, and sets the fill counters to fx=0, fy=0.
  - In FILL: one push per cycle whenever FIFO is not full, in row-major order.
  - After pushing (COLS-1, ROWS-1), returns to IDLE. Exactly COLS*ROWS entries are pushed.
  - The cursor (x,y) is not changed by a fill.
  - During FILL: a CHAR write is dropped and sets overflow. X/Y/attr/MODE writes take effect but do not alter the in-progress fill. A write to 0x09 is ignored.
- Reset in mid-fill or with a non-empty FIFO: everything is discarded, char_valid drops asynchronously, FSM returns to IDLE.

Decomposition:
- Shared package/header holds:
  - the register address constants (REG_CHAR .. REG_STATUS);
  - the MODE/STATUS bit positions;
  - the default COLS/ROWS, taken from the existing text-geometry constants.
- One sub-module: text_cell_fifo (synchronous FIFO, parameters WIDTH/DEPTH; outputs full, count, head), instantiated once.

Test Plan:
- Reset, then read 0x08 and 0x0A → 0x01 and 0x00. char_valid=0.
- X=0x4F, Y=0x18, attrs 0x12/0x34, CHAR=0x41 with char_ready=1 → one output beat with xtext=0x4F, ytext=0x18, charattr=0x341241. Then read X=0x00, Y=0x00 (double wrap).
- MODE=0x03, X=2, Y=24, CHAR twice → beats at (2,24) and (3,0).
- char_ready=0, five CHAR writes with FIFO_DEPTH=4 → four entries kept. STATUS=0x05. Cursor advanced by 4. Write 0x0A → STATUS=0x01.
- FILL=0x20 with char_ready toggling 1/0 → exactly 2000 beats in row-major order, all char 0x20. STATUS bit1 is high until the last push. A CHAR write during the fill sets overflow.
- Assert reset_n=0 in mid-fill → char_valid=0 immediately. After release: STATUS=0x00 and no further beats.

Source files
------------

// File: rtl/i2c_text_register_bank_pkg.sv
// Shared definitions for the I2C text register bank: register map, MODE/STATUS
// bit positions and the default text geometry of the VGA character generator.
package i2c_text_register_bank_pkg;

   localparam int TEXT_COLS = 80;
   localparam int TEXT_ROWS = 25;

   localparam logic [7:0] REG_CHAR   = 8'h00;
   localparam logic [7:0] REG_X      = 8'h01;
   localparam logic [7:0] REG_Y      = 8'h02;
   localparam logic [7:0] REG_ATTR0  = 8'h03;
   localparam logic [7:0] REG_MODE   = 8'h08;
   localparam logic [7:0] REG_FILL   = 8'h09;
   localparam logic [7:0] REG_STATUS = 8'h0A;

   localparam int MODE_AUTO_ADV    = 0;
   localparam int MODE_COL_MAJOR   = 1;

   localparam int STATUS_FULL      = 0;
   localparam int STATUS_FILL_BUSY = 1;
   localparam int STATUS_OVERFLOW  = 2;

   typedef enum logic {
      FSM_IDLE,
      FSM_FILL
   } fill_state_t;

endpackage

// File: rtl/i2c_text_register_bank_fifo.sv
// Synchronous FIFO holding text cells on their way to text memory.
// The head entry is always presented; a push into a full FIFO is refused.
module text_cell_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // Fullness comes from the registered count, so a same-cycle pop never makes room for a push
   assign full    = (count == FULL_COUNT);
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/i2c_text_register_bank.sv
// Register bank between the I2C slave byte engine and the text-memory writer:
// cursor/attribute registers, auto-advance, screen fill and a buffered cell stream.
module i2c_text_register_bank
   import i2c_text_register_bank_pkg::*;
#(
   parameter int COLS       = TEXT_COLS,
   parameter int ROWS       = TEXT_ROWS,
   parameter int ATTR_BYTES = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [7:0]                    addr,
   input  logic [7:0]                    dataIn,
   input  logic                          writeEn,
   output logic [7:0]                    dataOut,
   output logic                          char_valid,
   input  logic                          char_ready,
   output logic [7:0]                    xtext,
   output logic [7:0]                    ytext,
   output logic [8*(ATTR_BYTES+1)-1:0]   charattr
);

   localparam int CELL_W  = 8 * (ATTR_BYTES + 1);
   localparam int ENTRY_W = CELL_W + 16;
   localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [7:0] X_MAX = 8'(COLS - 1);
   localparam logic [7:0] Y_MAX = 8'(ROWS - 1);

   logic [7:0]                  x;
   logic [7:0]                  y;
   logic [7:0]                  char_reg;
   logic [ATTR_BYTES-1:0][7:0]  attr;
   logic [1:0]                  mode;
   logic                        overflow;

   fill_state_t                 state;
   logic [7:0]                  fx;
   logic [7:0]                  fy;
   logic [7:0]                  fill_char;
   logic [ATTR_BYTES-1:0][7:0]  fill_attr;

   logic                        fifo_full;
   logic [CNT_W-1:0]            fifo_count;
   logic [ENTRY_W-1:0]          fifo_head;
   logic                        push;
   logic [ENTRY_W-1:0]          push_data;

   logic                        in_fill;
   logic                        wr_char;
   logic                        char_push_ok;
   logic [7:0]                  adv_x;
   logic [7:0]                  adv_y;
   logic [7:0]                  rd_data;

   assign in_fill      = (state == FSM_FILL);
   assign wr_char      = writeEn && (addr == REG_CHAR);
   assign char_push_ok = wr_char && !in_fill && !fifo_full;

   // While filling, the fill engine owns the FIFO input; CHAR writes are refused
   always_comb begin
      push      = 1'b0;
      push_data = {x, y, attr, dataIn};
      if (in_fill) begin
         push      = !fifo_full;
         push_data = {fx, fy, fill_attr, fill_char};
      end else if (wr_char) begin
         push = !fifo_full;
      end
   end

   always_comb begin
      adv_x = x;
      adv_y = y;
      if (mode[MODE_COL_MAJOR]) begin
         if (y == Y_MAX) begin
            adv_y = '0;
            adv_x = (x == X_MAX) ? 8'd0 : x + 8'd1;
         end else begin
            adv_y = y + 8'd1;
         end
      end else begin
         if (x == X_MAX) begin
            adv_x = '0;
            adv_y = (y == Y_MAX) ? 8'd0 : y + 8'd1;
         end else begin
            adv_x = x + 8'd1;
         end
      end
   end

   // An explicit X/Y write lands after the advance so it wins when both happen
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x        <= '0;
         y        <= '0;
         char_reg <= '0;
         attr     <= '0;
         mode     <= 2'b01;
         overflow <= 1'b0;
      end else begin
         if (char_push_ok && mode[MODE_AUTO_ADV]) begin
            x <= adv_x;
            y <= adv_y;
         end
         if (writeEn) begin
            case (addr)
               REG_CHAR: begin
                  if (in_fill || fifo_full) overflow <= 1'b1;
                  if (!in_fill) char_reg <= dataIn;
               end
               REG_X:      x <= (dataIn > X_MAX) ? X_MAX : dataIn;
               REG_Y:      y <= (dataIn > Y_MAX) ? Y_MAX : dataIn;
               REG_MODE:   mode <= dataIn[1:0];
               REG_STATUS: overflow <= 1'b0;
               default: begin
                  for (int i = 0; i < ATTR_BYTES; i++) begin
                     if (addr == REG_ATTR0 + 8'(i)) attr[i] <= dataIn;
                  end
               end
            endcase
         end
      end
   end

   // Fill walks the whole screen row-major, one cell per cycle the FIFO can take
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FSM_IDLE;
         fx        <= '0;
         fy        <= '0;
         fill_char <= '0;
         fill_attr <= '0;
      end else begin
         case (state)
            FSM_IDLE: begin
               if (writeEn && addr == REG_FILL) begin
                  state     <= FSM_FILL;
                  fill_char <= dataIn;
                  fill_attr <= attr;
                  fx        <= '0;
                  fy        <= '0;
               end
            end
            FSM_FILL: begin
               if (!fifo_full) begin
                  if (fx == X_MAX) begin
                     fx <= '0;
                     if (fy == Y_MAX) begin
                        fy    <= '0;
                        state <= FSM_IDLE;
                     end else begin
                        fy <= fy + 8'd1;
                     end
                  end else begin
                     fx <= fx + 8'd1;
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (addr)
         REG_CHAR:   rd_data = char_reg;
         REG_X:      rd_data = x;
         REG_Y:      rd_data = y;
         REG_MODE:   rd_data = {6'b0, mode};
         REG_STATUS: begin
            rd_data[STATUS_FULL]      = fifo_full;
            rd_data[STATUS_FILL_BUSY] = in_fill;
            rd_data[STATUS_OVERFLOW]  = overflow;
         end
         default: begin
            for (int i = 0; i < ATTR_BYTES; i++) begin
               if (addr == REG_ATTR0 + 8'(i)) rd_data = attr[i];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dataOut <= '0;
      else          dataOut <= rd_data;
   end

   text_cell_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (char_ready),
      .full      (fifo_full),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign char_valid = (fifo_count != '0);
   assign charattr   = fifo_head[CELL_W-1:0];
   assign ytext      = fifo_head[CELL_W+7:CELL_W];
   assign xtext      = fifo_head[ENTRY_W-1:CELL_W+8];

endmodule

// File: tb/tb_i2c_text_register_bank.sv
// Self-checking bench for i2c_text_register_bank: a screen-level model (linear
// cell indices, a queue of pending cells) checked against the DUT every cycle.
module tb_i2c_text_register_bank;
   import i2c_text_register_bank_pkg::*;

   localparam int COLS       = 80;
   localparam int ROWS       = 25;
   localparam int ATTR_BYTES = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int CW         = 8 * (ATTR_BYTES + 1);

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [7:0]    addr = 8'hFF;
   logic [7:0]    dataIn = 8'h00;
   logic          writeEn = 1'b0;
   logic          char_ready = 1'b0;
   logic [7:0]    dataOut;
   logic          char_valid;
   logic [7:0]    xtext;
   logic [7:0]    ytext;
   logic [CW-1:0] charattr;

   int assertions = 0;
   int failures   = 0;

   typedef struct {
      int     x;
      int     y;
      longint ca;
   } beat_t;

   // Screen-level model state
   beat_t      mq[$];
   beat_t      beat_log[$];
   int         mx, my, mmode, movf, mfill, fill_idx, mchar;
   int         mattr[ATTR_BYTES];
   longint     fill_ca;
   logic [7:0] m_dout;
   int         m_sz;
   int         m_filling;

   i2c_text_register_bank #(
      .COLS(COLS), .ROWS(ROWS), .ATTR_BYTES(ATTR_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .addr       (addr),
      .dataIn     (dataIn),
      .writeEn    (writeEn),
      .dataOut    (dataOut),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .xtext      (xtext),
      .ytext      (ytext),
      .charattr   (charattr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic longint model_cell(input int c);
      longint v;
      v = longint'(c & 8'hFF);
      for (int i = 0; i < ATTR_BYTES; i++) v |= longint'(mattr[i] & 8'hFF) << (8 * (i + 1));
      return v;
   endfunction

   function automatic void model_push(input int px, input int py, input longint pca);
      beat_t b;
      b.x  = px;
      b.y  = py;
      b.ca = pca;
      mq.push_back(b);
   endfunction

   // Cursor advance as a step along the linear cell index in the scan order
   function automatic void model_advance();
      int idx;
      if ((mmode & 2) != 0) begin
         idx = (mx * ROWS + my + 1) % (COLS * ROWS);
         mx  = idx / ROWS;
         my  = idx % ROWS;
      end else begin
         idx = (my * COLS + mx + 1) % (COLS * ROWS);
         mx  = idx % COLS;
         my  = idx / COLS;
      end
   endfunction

   function automatic logic [7:0] model_read(input logic [7:0] a);
      int v;
      v = 0;
      if (a == REG_CHAR)        v = mchar;
      else if (a == REG_X)      v = mx;
      else if (a == REG_Y)      v = my;
      else if (a == REG_MODE)   v = mmode;
      else if (a == REG_STATUS) v = ((mq.size() == FIFO_DEPTH) ? 1 : 0) | (mfill << 1) | (movf << 2);
      else if (a >= 8'h03 && a < 8'(3 + ATTR_BYTES)) v = mattr[a - 8'h03];
      return 8'(v);
   endfunction

   // Model update on each rising edge, from the inputs driven at the falling edge
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         mx = 0; my = 0; mmode = 1; movf = 0; mfill = 0; fill_idx = 0; mchar = 0;
         for (int i = 0; i < ATTR_BYTES; i++) mattr[i] = 0;
         fill_ca = 0;
         m_dout  = 8'h00;
      end else begin
         m_sz      = mq.size();
         m_filling = mfill;
         m_dout    = model_read(addr);
         if (m_sz > 0 && char_ready) void'(mq.pop_front());
         if (m_filling != 0 && m_sz < FIFO_DEPTH) begin
            model_push(fill_idx % COLS, fill_idx / COLS, fill_ca);
            fill_idx++;
            if (fill_idx == COLS * ROWS) mfill = 0;
         end
         if (writeEn) begin
            if (addr == REG_CHAR) begin
               if (m_filling != 0) movf = 1;
               else begin
                  mchar = dataIn;
                  if (m_sz < FIFO_DEPTH) begin
                     model_push(mx, my, model_cell(dataIn));
                     if ((mmode & 1) != 0) model_advance();
                  end else movf = 1;
               end
            end else if (addr == REG_X) mx = (dataIn > COLS - 1) ? COLS - 1 : int'(dataIn);
            else if (addr == REG_Y) my = (dataIn > ROWS - 1) ? ROWS - 1 : int'(dataIn);
            else if (addr == REG_MODE) mmode = dataIn & 3;
            else if (addr == REG_FILL) begin
               if (m_filling == 0) begin
                  mfill    = 1;
                  fill_idx = 0;
                  fill_ca  = model_cell(dataIn);
               end
            end else if (addr == REG_STATUS) movf = 0;
            else if (addr >= 8'h03 && addr < 8'(3 + ATTR_BYTES)) mattr[addr - 8'h03] = dataIn;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model
   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("char_valid", char_valid, (mq.size() != 0) ? 1 : 0);
         if (mq.size() != 0) begin
            checkOutput("xtext", xtext, mq[0].x);
            checkOutput("ytext", ytext, mq[0].y);
            checkOutput("charattr", charattr, mq[0].ca);
         end
         checkOutput("dataOut", dataOut, m_dout);
      end
   end

   always @(posedge clk) begin
      if (reset_n && char_valid && char_ready) begin
         beat_t b;
         b.x  = xtext;
         b.y  = ytext;
         b.ca = charattr;
         beat_log.push_back(b);
      end
   end

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic we);
      @(negedge clk);
      addr    = a;
      dataIn  = d;
      writeEn = we;
   endtask

   task automatic writeReg(input logic [7:0] a, input logic [7:0] d);
      applyStimulus(a, d, 1'b1);
      applyStimulus(8'hFF, 8'h00, 1'b0);
   endtask

   task automatic readReg(input logic [7:0] a, input logic [7:0] expected, input string name);
      applyStimulus(a, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      checkOutput(name, dataOut, expected);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(8'hFF, 8'h00, 1'b0);
   endtask

   initial begin
      int errors;
      int done;
      int n_before;

      // Reset state
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      readReg(REG_MODE, 8'h01, "reset MODE");
      readReg(REG_STATUS, 8'h00, "reset STATUS");
      checkOutput("reset char_valid", char_valid, 0);

      // Single cell at the bottom-right corner, cursor wraps in both axes
      $display("[TB] corner write and double wrap");
      char_ready = 1'b1;
      beat_log.delete();
      writeReg(REG_X, 8'h4F);
      writeReg(REG_Y, 8'h18);
      writeReg(8'h03, 8'h12);
      writeReg(8'h04, 8'h34);
      writeReg(REG_CHAR, 8'h41);
      idle(3);
      checkOutput("corner beat count", beat_log.size(), 1);
      if (beat_log.size() >= 1) begin
         checkOutput("corner xtext", beat_log[0].x, 'h4F);
         checkOutput("corner ytext", beat_log[0].y, 'h18);
         checkOutput("corner charattr", beat_log[0].ca, 'h341241);
      end
      readReg(REG_X, 8'h00, "wrapped X");
      readReg(REG_Y, 8'h00, "wrapped Y");
      readReg(8'h04, 8'h34, "attr1 readback");
      readReg(8'h05, 8'h00, "unmapped read");

      // Column-major advance across the bottom row
      $display("[TB] column-major advance");
      beat_log.delete();
      writeReg(REG_MODE, 8'h03);
      writeReg(REG_X, 8'd2);
      writeReg(REG_Y, 8'd24);
      writeReg(REG_CHAR, 8'h42);
      writeReg(REG_CHAR, 8'h43);
      idle(3);
      checkOutput("colmajor beat count", beat_log.size(), 2);
      if (beat_log.size() >= 2) begin
         checkOutput("colmajor beat0 x", beat_log[0].x, 2);
         checkOutput("colmajor beat0 y", beat_log[0].y, 24);
         checkOutput("colmajor beat1 x", beat_log[1].x, 3);
         checkOutput("colmajor beat1 y", beat_log[1].y, 0);
         checkOutput("colmajor beat1 charattr", beat_log[1].ca, 'h341243);
      end
      readReg(REG_MODE, 8'h03, "MODE readback");
      writeReg(REG_X, 8'hC8);
      readReg(REG_X, 8'd79, "X clamp");

      // Overflow: five pushes into a stalled four-entry FIFO
      $display("[TB] FIFO overflow");
      writeReg(REG_MODE, 8'h01);
      writeReg(REG_X, 8'd0);
      writeReg(REG_Y, 8'd0);
      char_ready = 1'b0;
      for (int i = 0; i < 5; i++) writeReg(REG_CHAR, 8'(8'h61 + i));
      readReg(REG_STATUS, 8'h05, "full plus overflow");
      readReg(REG_X, 8'h04, "cursor after rejected push");
      writeReg(REG_STATUS, 8'hFF);
      readReg(REG_STATUS, 8'h01, "overflow cleared");
      beat_log.delete();
      char_ready = 1'b1;
      idle(8);
      checkOutput("drained beat count", beat_log.size(), 4);
      if (beat_log.size() >= 4) begin
         checkOutput("last kept x", beat_log[3].x, 3);
         checkOutput("last kept charattr", beat_log[3].ca, 'h341264);
      end

      // Screen fill with a stuttering consumer
      $display("[TB] screen fill");
      beat_log.delete();
      writeReg(REG_FILL, 8'h20);
      done = 0;
      for (int i = 0; i < 20000 && done == 0; i++) begin
         @(negedge clk);
         char_ready = ~char_ready;
         if (i == 5) checkOutput("fill busy", dataOut[1], 1);
         if (i == 10) begin
            addr = REG_CHAR; dataIn = 8'h55; writeEn = 1'b1;
         end else if (i == 20) begin
            addr = REG_FILL; dataIn = 8'h77; writeEn = 1'b1;
         end else begin
            addr = REG_STATUS; dataIn = 8'h00; writeEn = 1'b0;
         end
         done = (beat_log.size() >= COLS * ROWS && !char_valid) ? 1 : 0;
      end
      checkOutput("fill completed in budget", done, 1);
      checkOutput("fill beat count", beat_log.size(), 2000);
      errors = 0;
      for (int k = 0; k < beat_log.size(); k++) begin
         if (beat_log[k].x != k % COLS || beat_log[k].y != k / COLS || beat_log[k].ca != 'h341220)
            errors++;
      end
      checkOutput("fill order errors", errors, 0);
      char_ready = 1'b1;
      readReg(REG_STATUS, 8'h04, "overflow from CHAR during fill");
      readReg(REG_X, 8'h04, "cursor untouched by fill");
      writeReg(REG_STATUS, 8'h00);

      // Reset in the middle of a fill
      $display("[TB] reset during fill");
      writeReg(REG_FILL, 8'h2A);
      idle(50);
      #2;
      checkOutput("valid before reset", char_valid, 1);
      reset_n = 1'b0;
      #1;
      checkOutput("valid drops on reset", char_valid, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_before = beat_log.size();
      idle(20);
      readReg(REG_STATUS, 8'h00, "STATUS after reset");
      checkOutput("no beats after reset", beat_log.size() - n_before, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
